// File: rtl/booth_mac_acc.sv
// Saturating multiply-accumulate: sums LEN signed products behind a valid/ready input,
// then holds the dot-product result on a valid/ready output until it is consumed.
module booth_mac_acc #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [2*N-1:0]        prod_in,
  input  logic                         clear,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic signed [ACC_W-1:0]      acc_out,
  output logic                         acc_sat,
  output logic [$clog2(LEN+1)-1:0]     term_cnt
);

  localparam int CNT_W = $clog2(LEN+1);
  localparam logic [CNT_W-1:0]         LEN_C   = CNT_W'(LEN);
  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     live_q, live_d;

  logic                     accept;
  logic signed [ACC_W:0]    prod_ext;
  logic signed [ACC_W:0]    sum;

  always_comb begin
    live_d     = 1'b1;
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;

    // live_q keeps prod_ready low until the first edge after reset release
    prod_ready = live_q && (state_q == ACCUM);
    acc_valid  = (state_q == HOLD);
    accept     = prod_valid && prod_ready;

    prod_ext   = {{(ACC_W+1-2*N){prod_in[2*N-1]}}, prod_in};
    sum        = {acc_q[ACC_W-1], acc_q} + prod_ext;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == HOLD) begin
      if (acc_ready) begin
        state_d = ACCUM;
        acc_d   = '0;
        sat_d   = 1'b0;
        cnt_d   = '0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      // the two top bits of the widened sum disagree only on signed overflow
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (cnt_d == LEN_C) begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
    end
  end

  assign acc_out  = acc_q;
  assign acc_sat  = sat_q;
  assign term_cnt = cnt_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: a LEN=4/ACC_W=24 instance for sums, handshakes,
// clear and reset, plus a LEN=2/ACC_W=16 instance for saturation.
module tb_booth_mac_acc;

  logic clk;
  logic rst_n;

  logic               prod_valid, prod_ready, clear, acc_valid, acc_ready, acc_sat;
  logic signed [15:0] prod_in;
  logic signed [23:0] acc_out;
  logic [2:0]         term_cnt;

  logic               s_prod_valid, s_prod_ready, s_clear, s_acc_valid, s_acc_ready, s_acc_sat;
  logic signed [15:0] s_prod_in;
  logic signed [15:0] s_acc_out;
  logic [1:0]         s_term_cnt;

  int checks = 0;
  int errors = 0;

  booth_mac_acc #(.N(8), .ACC_W(24), .LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_in(prod_in),
    .clear(clear), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_out(acc_out), .acc_sat(acc_sat), .term_cnt(term_cnt)
  );

  booth_mac_acc #(.N(8), .ACC_W(16), .LEN(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(s_prod_valid), .prod_ready(s_prod_ready), .prod_in(s_prod_in),
    .clear(s_clear), .acc_valid(s_acc_valid), .acc_ready(s_acc_ready),
    .acc_out(s_acc_out), .acc_sat(s_acc_sat), .term_cnt(s_term_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] v);
    prod_valid = 1'b1;
    prod_in    = v;
    step();
    prod_valid = 1'b0;
  endtask

  task automatic s_push(input logic signed [15:0] v);
    s_prod_valid = 1'b1;
    s_prod_in    = v;
    step();
    s_prod_valid = 1'b0;
  endtask

  logic signed [15:0] basic_vec [4] = '{16'sd15, -16'sd14, 16'sd10000, 16'sd16384};
  logic               gap_vld   [10] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 1};
  int                 gap_cnt   [10] = '{1, 1, 1, 2, 3, 3, 3, 3, 3, 4};

  initial begin
    rst_n = 1'b0;
    prod_valid = 1'b0; prod_in = '0; clear = 1'b0; acc_ready = 1'b0;
    s_prod_valid = 1'b0; s_prod_in = '0; s_clear = 1'b0; s_acc_ready = 1'b0;

    #12;
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_acc_sat", acc_sat, 0);
    chk("rst_term_cnt", term_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_prod_ready_before_edge", prod_ready, 0);
    step();
    chk("rel_prod_ready_after_edge", prod_ready, 1);

    // basic dot product
    for (int i = 0; i < 4; i++) begin
      chk("basic_valid_low", acc_valid, 0);
      push(basic_vec[i]);
      chk("basic_cnt", term_cnt, i + 1);
    end
    chk("basic_acc_valid", acc_valid, 1);
    chk("basic_acc_out", acc_out, 26385);
    chk("basic_acc_sat", acc_sat, 0);
    chk("basic_prod_ready", prod_ready, 0);

    // backpressure: result held, incoming products ignored
    prod_valid = 1'b1; prod_in = 16'sd999;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_prod_ready", prod_ready, 0);
      chk("bp_acc_valid", acc_valid, 1);
      chk("bp_acc_out", acc_out, 26385);
      chk("bp_term_cnt", term_cnt, 4);
    end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("pop_acc_valid", acc_valid, 0);
    chk("pop_term_cnt", term_cnt, 0);
    chk("pop_prod_ready", prod_ready, 1);
    chk("pop_acc_out", acc_out, 0);

    // gapped valid
    for (int c = 0; c < 10; c++) begin
      prod_valid = gap_vld[c];
      prod_in    = 16'sd1;
      step();
      chk("gap_cnt", term_cnt, gap_cnt[c]);
      chk("gap_valid", acc_valid, (c == 9) ? 1 : 0);
    end
    prod_valid = 1'b0;
    chk("gap_acc_out", acc_out, 4);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;

    // clear mid-operation drops the concurrent product
    push(16'sd5);
    push(16'sd5);
    chk("pre_clear_cnt", term_cnt, 2);
    clear = 1'b1; prod_valid = 1'b1; prod_in = 16'sd7;
    step();
    clear = 1'b0; prod_valid = 1'b0;
    chk("clear_cnt", term_cnt, 0);
    chk("clear_acc_out", acc_out, 0);
    chk("clear_acc_valid", acc_valid, 0);
    for (int i = 0; i < 4; i++) push(16'sd2);
    chk("post_clear_valid", acc_valid, 1);
    chk("post_clear_acc_out", acc_out, 8);

    // clear beats acc_ready in HOLD
    clear = 1'b1; acc_ready = 1'b1;
    step();
    clear = 1'b0; acc_ready = 1'b0;
    chk("hold_clear_valid", acc_valid, 0);
    chk("hold_clear_out", acc_out, 0);
    chk("hold_clear_cnt", term_cnt, 0);

    // saturation, ACC_W=16 LEN=2
    s_push(16'sd16384);
    chk("sat_pos_mid", s_acc_sat, 0);
    s_push(16'sd16384);
    chk("sat_pos_valid", s_acc_valid, 1);
    chk("sat_pos_out", s_acc_out, 32767);
    chk("sat_pos_flag", s_acc_sat, 1);
    s_acc_ready = 1'b1;
    step();
    s_acc_ready = 1'b0;
    chk("sat_pop_flag", s_acc_sat, 0);
    s_push(-16'sd32768);
    chk("sat_neg_mid_out", s_acc_out, -32768);
    chk("sat_neg_mid_flag", s_acc_sat, 0);
    s_push(-16'sd1);
    chk("sat_neg_out", s_acc_out, -32768);
    chk("sat_neg_flag", s_acc_sat, 1);
    chk("sat_neg_valid", s_acc_valid, 1);

    // async reset during HOLD
    for (int i = 0; i < 4; i++) push(16'sd1);
    chk("pre_arst_valid", acc_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc_valid", acc_valid, 0);
    chk("arst_acc_out", acc_out, 0);
    chk("arst_prod_ready", prod_ready, 0);
    chk("arst_s_acc_valid", s_acc_valid, 0);
    #4;
    rst_n = 1'b1;
    step();
    chk("arst_rel_ready", prod_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
